// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the 5-stage pipeline hazard controller:
//   - EX operand forwarding select encodings
//   - per-slot control flags shadowed for the instruction sitting in EX
//   - legal redirect-resolution stages and a check helper
// -----------------------------------------------------------------------------
package pipe_pkg;

    // EX operand source selects
    localparam logic [1:0] FWD_RF    = 2'b00;   // register file read
    localparam logic [1:0] FWD_EXMEM = 2'b01;   // EX/MEM ALU result
    localparam logic [1:0] FWD_MEMWB = 2'b10;   // MEM/WB write-back data

    // Stages in which a taken branch / jump may be resolved
    localparam int BR_STAGE_EX  = 3;
    localparam int BR_STAGE_MEM = 4;

    function automatic bit br_stage_legal(input int stage);
        return (stage == BR_STAGE_EX) || (stage == BR_STAGE_MEM);
    endfunction

    // Control flags carried by the EX slot. A bubble or a squashed
    // instruction is represented by all-zero flags.
    typedef struct packed {
        logic wr;   // writes a register
        logic ld;   // is a load (result only available after MEM)
    } slot_t;

endpackage

// File: rtl/hz_sat_cnt.sv
// -----------------------------------------------------------------------------
// hz_sat_cnt
// Saturating up-counter used for the stall and flush statistics.
// Ports:
//   clk    in   clock
//   rst_n  in   synchronous active-low reset, clears the count
//   inc    in   add one on the next rising edge (held at all-ones once full)
//   cnt    out  CNT_W-bit count
// -----------------------------------------------------------------------------
module hz_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard, forwarding and redirect controller for a 5-stage pipeline
// (IF, ID, EX, MEM, WB). Shadows destination/load info of the in-flight
// instructions and drives pipeline register enables, bubbles, flushes and
// forwarding selects. Never touches datapath values.
//
// Build option: define HZ_FWD_EN to enable EX forwarding and the ID
// write-back bypass; only load-use then stalls. Without it every RAW
// dependency on EX/MEM/WB stalls and all selects are tied to the register file.
//
// Parameters: REG_AW (register address width), BR_STAGE (3 = EX, 4 = MEM),
//             CNT_W (statistic counter width)
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   id_valid                         ID holds a real instruction
//   id_rs, id_rt, id_use_rs/rt       ID source registers and whether read
//   id_dst, id_regwr, id_load        ID destination, writes-register, is-load
//   redirect                         taken branch / jump resolved in BR_STAGE
//   pc_we, ifid_we                   PC and IF/ID write enables
//   bubble_idex                      load NOP into ID/EX
//   flush_ifid/idex/exmem            squash the named pipeline register
//   pc_sel_redirect                  PC takes the redirect target
//   fwd_a, fwd_b                     EX operand selects
//   id_byp_a, id_byp_b               ID operand takes WB write data
//   stall_cnt, flush_cnt             saturating event counters
// All control outputs are combinational; every output reads 0 during reset.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int BR_STAGE = 3,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_regwr,
    input  logic              id_load,
    input  logic              redirect,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              bubble_idex,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              flush_exmem,
    output logic              pc_sel_redirect,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              id_byp_a,
    output logic              id_byp_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    generate
        if (!br_stage_legal(BR_STAGE)) begin : g_bad_br_stage
            $error("pipe_hazard_ctrl: BR_STAGE must be 3 (EX) or 4 (MEM)");
        end
    endgenerate

    // When resolving in MEM the instruction behind the branch is already in
    // EX and must be squashed on its way into EX/MEM.
    localparam logic SQUASH_EXMEM = (BR_STAGE == BR_STAGE_MEM);

    // Shadow slots, one per pipeline register
    slot_t             ex_slot;
    logic [REG_AW-1:0] ex_dst;
    logic              mem_wr;
    logic [REG_AW-1:0] mem_dst;
    logic              wb_wr;
    logic [REG_AW-1:0] wb_dst;

    logic              rs_rd;
    logic              rt_rd;
    logic              hazard;
    logic              stall;
    logic [1:0]        fwd_a_c;
    logic [1:0]        fwd_b_c;
    logic              byp_a_c;
    logic              byp_b_c;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;

    // Register 0 is hard-wired, so it can never carry a dependency.
    function automatic logic src_hit(input logic [REG_AW-1:0] src,
                                     input logic              used,
                                     input logic [REG_AW-1:0] dst,
                                     input logic              wr);
        return used && wr && (src != '0) && (src == dst);
    endfunction

    assign rs_rd = id_valid && id_use_rs;
    assign rt_rd = id_valid && id_use_rt;

`ifdef HZ_FWD_EN
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic              ex_use_rs;
    logic              ex_use_rt;

    // Everything except a load result can be forwarded in time.
    assign hazard = src_hit(id_rs, rs_rd, ex_dst, ex_slot.wr && ex_slot.ld) ||
                    src_hit(id_rt, rt_rd, ex_dst, ex_slot.wr && ex_slot.ld);

    // MEM is checked first: it holds the younger producer.
    always_comb begin
        fwd_a_c = FWD_RF;
        fwd_b_c = FWD_RF;
        if (src_hit(ex_rs, ex_use_rs, mem_dst, mem_wr)) begin
            fwd_a_c = FWD_EXMEM;
        end else if (src_hit(ex_rs, ex_use_rs, wb_dst, wb_wr)) begin
            fwd_a_c = FWD_MEMWB;
        end
        if (src_hit(ex_rt, ex_use_rt, mem_dst, mem_wr)) begin
            fwd_b_c = FWD_EXMEM;
        end else if (src_hit(ex_rt, ex_use_rt, wb_dst, wb_wr)) begin
            fwd_b_c = FWD_MEMWB;
        end
    end

    // Register file writes in WB and reads in ID in the same cycle.
    assign byp_a_c = src_hit(id_rs, 1'b1, wb_dst, wb_wr);
    assign byp_b_c = src_hit(id_rt, 1'b1, wb_dst, wb_wr);

    always_ff @(posedge clk) begin
        if (!rst_n || redirect || stall) begin
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_use_rs <= 1'b0;
            ex_use_rt <= 1'b0;
        end else begin
            ex_rs     <= id_rs;
            ex_rt     <= id_rt;
            ex_use_rs <= rs_rd;
            ex_use_rt <= rt_rd;
        end
    end
`else
    // No forwarding: wait until the producer has left WB.
    assign hazard = src_hit(id_rs, rs_rd, ex_dst,  ex_slot.wr) ||
                    src_hit(id_rs, rs_rd, mem_dst, mem_wr)     ||
                    src_hit(id_rs, rs_rd, wb_dst,  wb_wr)      ||
                    src_hit(id_rt, rt_rd, ex_dst,  ex_slot.wr) ||
                    src_hit(id_rt, rt_rd, mem_dst, mem_wr)     ||
                    src_hit(id_rt, rt_rd, wb_dst,  wb_wr);

    assign fwd_a_c = FWD_RF;
    assign fwd_b_c = FWD_RF;
    assign byp_a_c = 1'b0;
    assign byp_b_c = 1'b0;
`endif

    // A redirect squashes the ID instruction, so its stall is moot.
    assign stall = hazard && !redirect;

    always_comb begin
        pc_we           = 1'b0;
        ifid_we         = 1'b0;
        bubble_idex     = 1'b0;
        flush_ifid      = 1'b0;
        flush_idex      = 1'b0;
        flush_exmem     = 1'b0;
        pc_sel_redirect = 1'b0;
        fwd_a           = FWD_RF;
        fwd_b           = FWD_RF;
        id_byp_a        = 1'b0;
        id_byp_b        = 1'b0;
        if (rst_n) begin
            pc_we    = 1'b1;
            ifid_we  = 1'b1;
            fwd_a    = fwd_a_c;
            fwd_b    = fwd_b_c;
            id_byp_a = byp_a_c;
            id_byp_b = byp_b_c;
            if (redirect) begin
                pc_sel_redirect = 1'b1;
                flush_ifid      = 1'b1;
                flush_idex      = 1'b1;
                flush_exmem     = SQUASH_EXMEM;
            end else if (stall) begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                bubble_idex = 1'b1;
            end
        end
    end

    // Slot pipeline: mem and wb keep advancing during a stall, only the
    // entry into EX becomes a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_slot <= '0;
            ex_dst  <= '0;
            mem_wr  <= 1'b0;
            mem_dst <= '0;
            wb_wr   <= 1'b0;
            wb_dst  <= '0;
        end else begin
            if (redirect || stall) begin
                ex_slot <= '0;
                ex_dst  <= '0;
            end else begin
                ex_slot.wr <= id_valid && id_regwr;
                ex_slot.ld <= id_valid && id_load;
                ex_dst     <= id_dst;
            end
            mem_wr  <= ex_slot.wr && !(redirect && SQUASH_EXMEM);
            mem_dst <= ex_dst;
            wb_wr   <= mem_wr;
            wb_dst  <= mem_dst;
        end
    end

    hz_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall),
        .cnt   (stall_cnt_q)
    );

    hz_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (redirect),
        .cnt   (flush_cnt_q)
    );

    assign stall_cnt = rst_n ? stall_cnt_q : '0;
    assign flush_cnt = rst_n ? flush_cnt_q : '0;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a BR_STAGE=3 instance with
// 32-bit counters and a BR_STAGE=4 instance with 2-bit counters share the
// same stimulus. Expectations are hand-derived per build (HZ_FWD_EN).
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] dst;
        logic       wr;
        logic       ld;
    } id_t;

    typedef struct packed {
        logic       pc_we;
        logic       ifid_we;
        logic       bubble;
        logic       f_ifid;
        logic       f_idex;
        logic       f_exmem;
        logic       pc_sel;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       ba;
        logic       bb;
    } outs_t;

    typedef struct packed {
        logic       rst_n;
        id_t        id;
        logic       redir;
        outs_t      exp;
        logic [7:0] sc;
        logic [7:0] fc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_use_rs, id_use_rt, id_regwr, id_load, redirect;
    logic [4:0]  id_rs, id_rt, id_dst;

    logic        pc_we, ifid_we, bubble_idex, flush_ifid, flush_idex, flush_exmem, pc_sel_redirect;
    logic [1:0]  fwd_a, fwd_b;
    logic        id_byp_a, id_byp_b;
    logic [31:0] stall_cnt, flush_cnt;

    logic        pc_we4, ifid_we4, bubble_idex4, flush_ifid4, flush_idex4, flush_exmem4, pc_sel_redirect4;
    logic [1:0]  fwd_a4, fwd_b4;
    logic        id_byp_a4, id_byp_b4;
    logic [1:0]  stall_cnt4, flush_cnt4;

    int tests = 0;
    int fails = 0;

    vec_t tv[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(5), .BR_STAGE(3), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst), .id_regwr(id_regwr),
        .id_load(id_load), .redirect(redirect), .pc_we(pc_we), .ifid_we(ifid_we),
        .bubble_idex(bubble_idex), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .flush_exmem(flush_exmem), .pc_sel_redirect(pc_sel_redirect), .fwd_a(fwd_a),
        .fwd_b(fwd_b), .id_byp_a(id_byp_a), .id_byp_b(id_byp_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .BR_STAGE(4), .CNT_W(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst), .id_regwr(id_regwr),
        .id_load(id_load), .redirect(redirect), .pc_we(pc_we4), .ifid_we(ifid_we4),
        .bubble_idex(bubble_idex4), .flush_ifid(flush_ifid4), .flush_idex(flush_idex4),
        .flush_exmem(flush_exmem4), .pc_sel_redirect(pc_sel_redirect4), .fwd_a(fwd_a4),
        .fwd_b(fwd_b4), .id_byp_a(id_byp_a4), .id_byp_b(id_byp_b4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    function automatic id_t alu(input int d, input int s, input int t);
        id_t r = '0;
        r.valid = 1'b1; r.rs = 5'(s); r.rt = 5'(t); r.urs = 1'b1; r.urt = 1'b1;
        r.dst = 5'(d); r.wr = 1'b1;
        return r;
    endfunction

    function automatic id_t lw(input int d, input int b);
        id_t r = '0;
        r.valid = 1'b1; r.rs = 5'(b); r.urs = 1'b1; r.dst = 5'(d); r.wr = 1'b1; r.ld = 1'b1;
        return r;
    endfunction

    function automatic outs_t o(input logic pw, input logic iw, input logic bub, input logic red);
        outs_t r = '0;
        r.pc_we = pw; r.ifid_we = iw; r.bubble = bub;
        r.f_ifid = red; r.f_idex = red; r.pc_sel = red;
        return r;
    endfunction

    function automatic outs_t f(input outs_t b, input logic [1:0] fa, input logic [1:0] fb,
                                input logic ba, input logic bb);
        outs_t r = b;
        r.fa = fa; r.fb = fb; r.ba = ba; r.bb = bb;
        return r;
    endfunction

    function automatic logic [1:0] sat2(input logic [7:0] x);
        return (x > 8'd3) ? 2'd3 : x[1:0];
    endfunction

    localparam id_t NOP = '0;
    outs_t ZERO, NORM, STALL, REDIR;

    task automatic v(input logic r, input id_t i, input logic rd, input outs_t e,
                     input int sc, input int fc);
        vec_t t;
        t.rst_n = r; t.id = i; t.redir = rd; t.exp = e; t.sc = 8'(sc); t.fc = 8'(fc);
        tv.push_back(t);
    endtask

    task automatic check(input vec_t e, input int idx);
        outs_t g3, g4, e4;
        g3 = {pc_we, ifid_we, bubble_idex, flush_ifid, flush_idex, flush_exmem,
              pc_sel_redirect, fwd_a, fwd_b, id_byp_a, id_byp_b};
        g4 = {pc_we4, ifid_we4, bubble_idex4, flush_ifid4, flush_idex4, flush_exmem4,
              pc_sel_redirect4, fwd_a4, fwd_b4, id_byp_a4, id_byp_b4};
        e4 = e.exp;
        e4.f_exmem = e.exp.pc_sel;
        tests++;
        if (g3 !== e.exp) begin
            fails++;
            $display("FAIL outs_br3 vec %0d: got %b want %b", idx, g3, e.exp);
        end
        tests++;
        if (g4 !== e4) begin
            fails++;
            $display("FAIL outs_br4 vec %0d: got %b want %b", idx, g4, e4);
        end
        tests++;
        if (stall_cnt !== 32'(e.sc) || flush_cnt !== 32'(e.fc)) begin
            fails++;
            $display("FAIL counters vec %0d: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                     idx, stall_cnt, flush_cnt, e.sc, e.fc);
        end
        tests++;
        if (stall_cnt4 !== sat2(e.sc) || flush_cnt4 !== sat2(e.fc)) begin
            fails++;
            $display("FAIL sat_counters vec %0d: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                     idx, stall_cnt4, flush_cnt4, sat2(e.sc), sat2(e.fc));
        end
    endtask

    task automatic step(input vec_t t, input int idx);
        vec_t e;
        @(posedge clk);
        #1;
        rst_n     = t.rst_n;
        id_valid  = t.id.valid;
        id_rs     = t.id.rs;
        id_rt     = t.id.rt;
        id_use_rs = t.id.urs;
        id_use_rt = t.id.urt;
        id_dst    = t.id.dst;
        id_regwr  = t.id.wr;
        id_load   = t.id.ld;
        redirect  = t.redir;
        sb.push_back(t);
        @(negedge clk);
        e = sb.pop_front();
        check(e, idx);
    endtask

    initial begin
        vec_t t;
        ZERO  = '0;
        NORM  = o(1, 1, 0, 0);
        STALL = o(0, 0, 1, 0);
        REDIR = o(1, 1, 0, 1);

        rst_n = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0;
        id_use_rt = 1'b0; id_dst = '0; id_regwr = 1'b0; id_load = 1'b0; redirect = 1'b0;

`ifdef HZ_FWD_EN
        // forwarding paths, ID bypass, register 0, youngest producer
        v(0, lw(3, 1),     1, ZERO, 0, 0);
        v(0, lw(3, 1),     1, ZERO, 0, 0);
        v(1, alu(4, 3, 3), 0, NORM, 0, 0);
        v(1, alu(3, 1, 2), 0, NORM, 0, 0);
        v(1, alu(4, 3, 5), 0, NORM, 0, 0);
        v(1, NOP,          0, f(NORM, 2'b01, 2'b00, 0, 0), 0, 0);
        v(1, alu(3, 1, 2), 0, NORM, 0, 0);
        v(1, NOP,          0, NORM, 0, 0);
        v(1, alu(4, 3, 5), 0, NORM, 0, 0);
        v(1, alu(8, 0, 3), 0, f(NORM, 2'b10, 2'b00, 0, 1), 0, 0);
        v(1, alu(0, 1, 2), 0, NORM, 0, 0);
        v(1, alu(7, 0, 0), 0, NORM, 0, 0);
        v(1, NOP,          0, NORM, 0, 0);
        v(1, alu(9, 1, 2), 0, NORM, 0, 0);
        v(1, alu(9, 9, 1), 0, NORM, 0, 0);
        v(1, alu(10, 9, 9), 0, f(NORM, 2'b01, 2'b00, 0, 0), 0, 0);
        v(1, NOP,          0, f(NORM, 2'b01, 2'b01, 0, 0), 0, 0);
        // load-use, redirect priority, counters, reset mid-stall
        v(0, NOP,          0, ZERO, 0, 0);
        v(1, lw(3, 1),     0, NORM, 0, 0);
        v(1, alu(4, 1, 3), 0, STALL, 0, 0);
        v(1, alu(4, 1, 3), 0, NORM, 1, 0);
        v(1, NOP,          0, f(NORM, 2'b00, 2'b10, 0, 0), 1, 0);
        v(1, lw(5, 1),     0, NORM, 1, 0);
        v(1, alu(6, 5, 2), 1, REDIR, 1, 0);
        v(1, NOP,          0, NORM, 1, 1);
        v(1, NOP,          1, REDIR, 1, 1);
        v(1, NOP,          1, REDIR, 1, 2);
        v(1, NOP,          0, NORM, 1, 3);
        v(1, NOP,          1, REDIR, 1, 3);
        v(1, NOP,          0, NORM, 1, 4);
        v(1, lw(3, 1),     0, NORM, 1, 4);
        v(0, alu(4, 1, 3), 0, ZERO, 0, 0);
        v(1, alu(4, 1, 3), 0, NORM, 0, 0);
`else
        // full RAW interlock, register 0
        v(0, lw(3, 1),     1, ZERO, 0, 0);
        v(0, lw(3, 1),     1, ZERO, 0, 0);
        v(1, alu(4, 3, 3), 0, NORM, 0, 0);
        v(1, alu(3, 1, 2), 0, NORM, 0, 0);
        v(1, alu(6, 3, 0), 0, STALL, 0, 0);
        v(1, alu(6, 3, 0), 0, STALL, 1, 0);
        v(1, alu(6, 3, 0), 0, STALL, 2, 0);
        v(1, alu(6, 3, 0), 0, NORM, 3, 0);
        v(1, NOP,          0, NORM, 3, 0);
        v(1, alu(0, 1, 2), 0, NORM, 3, 0);
        v(1, alu(7, 0, 0), 0, NORM, 3, 0);
        // load dependency, redirect priority, counters, reset mid-stall
        v(0, NOP,          0, ZERO, 0, 0);
        v(1, lw(3, 1),     0, NORM, 0, 0);
        v(1, alu(4, 1, 3), 0, STALL, 0, 0);
        v(1, alu(4, 1, 3), 0, STALL, 1, 0);
        v(1, alu(4, 1, 3), 0, STALL, 2, 0);
        v(1, alu(4, 1, 3), 0, NORM, 3, 0);
        v(1, NOP,          0, NORM, 3, 0);
        v(1, lw(5, 1),     0, NORM, 3, 0);
        v(1, alu(6, 5, 2), 1, REDIR, 3, 0);
        v(1, NOP,          0, NORM, 3, 1);
        v(1, NOP,          1, REDIR, 3, 1);
        v(1, NOP,          1, REDIR, 3, 2);
        v(1, NOP,          0, NORM, 3, 3);
        v(1, NOP,          1, REDIR, 3, 3);
        v(1, NOP,          0, NORM, 3, 4);
        v(1, lw(3, 1),     0, NORM, 3, 4);
        v(0, alu(4, 1, 3), 0, ZERO, 0, 0);
        v(1, alu(4, 1, 3), 0, NORM, 0, 0);
`endif

        for (int k = 0; k < tv.size(); k++) begin
            step(tv[k], k);
        end

        // redirect held for several cycles: one flush count per cycle,
        // narrow counter pins at all-ones
        t = '0;
        t.exp = ZERO;
        step(t, 1000);
        for (int j = 0; j < 6; j++) begin
            t.rst_n = 1'b1; t.id = NOP; t.redir = 1'b1; t.exp = REDIR;
            t.sc = 8'd0; t.fc = 8'(j);
            step(t, 1001 + j);
        end
        t.redir = 1'b0; t.exp = NORM; t.fc = 8'd6;
        step(t, 1007);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
